// File: rtl/aes_vector_checker.sv
// Replays stored AES known-answer vectors through an external core and tallies
// pass/fail/timeout results for each run.
module aes_vector_checker #(
  parameter int unsigned N_VEC      = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP        = 2,
  parameter int unsigned SHARED_KEY = 0,
  localparam int unsigned AW = (N_VEC > 1) ? $clog2(N_VEC) : 1,
  localparam int unsigned CW = $clog2(N_VEC + 1)
) (
  input  logic          AES_clk,
  input  logic          AES_rst,
  input  logic          vec_wr_en,
  input  logic [AW-1:0] vec_wr_addr,
  input  logic [127:0]  vec_wr_pt,
  input  logic [127:0]  vec_wr_key,
  input  logic [127:0]  vec_wr_ct,
  input  logic          start,
  input  logic          abort,
  output logic          core_en,
  output logic [127:0]  core_data_in,
  output logic [127:0]  core_key_in,
  input  logic [127:0]  core_data_out,
  input  logic          core_data_out_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [AW-1:0] first_fail_idx,
  output logic          fail_seen,
  output logic          timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          en_q, en_d;
  logic [127:0]  din_q, din_d;
  logic [127:0]  kin_q, kin_d;
  logic [127:0]  cap_q, cap_d;
  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [AW-1:0] ffi_q, ffi_d;
  logic          fseen_q, fseen_d;
  logic          terr_q, terr_d;

  logic          wr_ok;
  logic          rec_fail;
  logic [127:0]  pt_rd, key_rd, ct_rd;

  // Vector storage deliberately has no reset so contents survive AES_rst.
  logic [127:0] pt_mem  [N_VEC];
  logic [127:0] key_mem [N_VEC];
  logic [127:0] ct_mem  [N_VEC];

  always_comb begin
    wr_ok  = vec_wr_en && (state_q == S_IDLE) && (32'(vec_wr_addr) < N_VEC);
    pt_rd  = pt_mem[idx_q];
    key_rd = (SHARED_KEY != 0) ? key_mem[0] : key_mem[idx_q];
    ct_rd  = ct_mem[idx_q];
  end

  always_ff @(posedge AES_clk) begin
    if (wr_ok) begin
      pt_mem[vec_wr_addr]  <= vec_wr_pt;
      key_mem[vec_wr_addr] <= vec_wr_key;
      ct_mem[vec_wr_addr]  <= vec_wr_ct;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    en_d     = en_q;
    din_d    = din_q;
    kin_d    = kin_q;
    cap_d    = cap_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffi_d    = ffi_q;
    fseen_d  = fseen_q;
    terr_d   = terr_q;
    rec_fail = 1'b0;

    // Abort freezes counters at their current values rather than committing
    // whatever result the aborted cycle would have produced.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_ISSUE;
            idx_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            ffi_d   = '0;
            fseen_d = 1'b0;
            terr_d  = 1'b0;
          end
        end
        S_ISSUE: begin
          en_d    = 1'b1;
          din_d   = pt_rd;
          kin_d   = key_rd;
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (core_data_out_valid) begin
            cap_d   = core_data_out;
            en_d    = 1'b0;
            state_d = S_CHECK;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rec_fail = 1'b1;
            terr_d   = 1'b1;
            en_d     = 1'b0;
            gap_d    = '0;
            state_d  = S_GAP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (cap_q == ct_rd) pass_d = pass_q + 1'b1;
          else                rec_fail = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
        S_GAP: begin
          if (gap_q == GW'(GAP - 1)) begin
            if (idx_q == AW'(N_VEC - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_ISSUE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (rec_fail) begin
        fail_d = fail_q + 1'b1;
        if (!fseen_q) begin
          ffi_d   = idx_q;
          fseen_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= '0;
      kin_q   <= '0;
      cap_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      fseen_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      din_q   <= din_d;
      kin_q   <= kin_d;
      cap_q   <= cap_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      fseen_q <= fseen_d;
      terr_q  <= terr_d;
    end
  end

  assign core_en        = en_q;
  assign core_data_in   = din_q;
  assign core_key_in    = kin_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign fail_seen      = fseen_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_aes_vector_checker.sv
// Scoreboard bench for aes_vector_checker: two instances (per-vector key and
// shared key) driven by a lookup-table AES core stub.
module tb_aes_vector_checker;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    int unsigned pass_n;
    int unsigned fail_n;
    int unsigned ffi;
    bit          fseen;
    bit          terr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_wr_en, a_start, a_abort, a_en, a_valid, a_busy, a_done, a_fseen, a_terr;
  logic [0:0]   a_wr_addr, a_ffi;
  logic [127:0] a_wr_pt, a_wr_key, a_wr_ct, a_din, a_kin, a_dout;
  logic [1:0]   a_pass, a_fail;
  logic         b_wr_en, b_start, b_abort, b_en, b_valid, b_busy, b_done, b_fseen, b_terr;
  logic [0:0]   b_wr_addr, b_ffi;
  logic [127:0] b_wr_pt, b_wr_key, b_wr_ct, b_din, b_kin, b_dout;
  logic [1:0]   b_pass, b_fail;
  logic         stub_mute;
  int           a_cnt = 0;
  int           b_cnt = 0;

  aes_vector_checker #(.N_VEC(2), .TIMEOUT(8), .GAP(2), .SHARED_KEY(0)) dut_a (
    .AES_clk(clk), .AES_rst(rst), .vec_wr_en(a_wr_en), .vec_wr_addr(a_wr_addr),
    .vec_wr_pt(a_wr_pt), .vec_wr_key(a_wr_key), .vec_wr_ct(a_wr_ct),
    .start(a_start), .abort(a_abort), .core_en(a_en), .core_data_in(a_din),
    .core_key_in(a_kin), .core_data_out(a_dout), .core_data_out_valid(a_valid),
    .busy(a_busy), .done(a_done), .pass_cnt(a_pass), .fail_cnt(a_fail),
    .first_fail_idx(a_ffi), .fail_seen(a_fseen), .timeout_err(a_terr));

  aes_vector_checker #(.N_VEC(2), .TIMEOUT(64), .GAP(3), .SHARED_KEY(1)) dut_b (
    .AES_clk(clk), .AES_rst(rst), .vec_wr_en(b_wr_en), .vec_wr_addr(b_wr_addr),
    .vec_wr_pt(b_wr_pt), .vec_wr_key(b_wr_key), .vec_wr_ct(b_wr_ct),
    .start(b_start), .abort(b_abort), .core_en(b_en), .core_data_in(b_din),
    .core_key_in(b_kin), .core_data_out(b_dout), .core_data_out_valid(b_valid),
    .busy(b_busy), .done(b_done), .pass_cnt(b_pass), .fail_cnt(b_fail),
    .first_fail_idx(b_ffi), .fail_seen(b_fseen), .timeout_err(b_terr));

  // Core stub: knows the two FIPS-197 answers, otherwise returns pt ^ key.
  function automatic logic [127:0] stub_aes(input logic [127:0] pt, input logic [127:0] key);
    if (pt == PT0 && key == KEY0) return CT0;
    if (pt == PT1 && key == KEY1) return CT1;
    return pt ^ key;
  endfunction

  // Valid is raised once, in the 5th cycle that core_en has been high.
  always @(posedge clk) begin
    a_valid <= 1'b0;
    if (!a_en) a_cnt <= 0;
    else begin
      a_cnt <= a_cnt + 1;
      if (a_cnt == 3 && !stub_mute) begin
        a_valid <= 1'b1;
        a_dout  <= stub_aes(a_din, a_kin);
      end
    end
  end

  always @(posedge clk) begin
    b_valid <= 1'b0;
    if (!b_en) b_cnt <= 0;
    else begin
      b_cnt <= b_cnt + 1;
      if (b_cnt == 3) begin
        b_valid <= 1'b1;
        b_dout  <= stub_aes(b_din, b_kin);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard monitors: each done pulse pops one expected end-of-run record.
  always @(negedge clk) begin
    if (a_done) begin
      if (qa.size() == 0) chk_fail("a_unexpected_done");
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_pass_cnt", 128'(a_pass), 128'(e.pass_n));
        chk("a_fail_cnt", 128'(a_fail), 128'(e.fail_n));
        chk("a_fail_seen", 128'(a_fseen), 128'(e.fseen));
        chk("a_first_fail_idx", 128'(a_ffi), 128'(e.ffi));
        chk("a_timeout_err", 128'(a_terr), 128'(e.terr));
      end
    end
    if (b_done) begin
      if (qb.size() == 0) chk_fail("b_unexpected_done");
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_pass_cnt", 128'(b_pass), 128'(e.pass_n));
        chk("b_fail_cnt", 128'(b_fail), 128'(e.fail_n));
        chk("b_fail_seen", 128'(b_fseen), 128'(e.fseen));
        chk("b_timeout_err", 128'(b_terr), 128'(e.terr));
      end
    end
  end

  task automatic wr_a(input logic [0:0] addr, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct);
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_pt = pt; a_wr_key = key; a_wr_ct = ct;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic wr_b(input logic [0:0] addr, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct);
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_pt = pt; b_wr_key = key; b_wr_ct = ct;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic push_a(input int unsigned p, input int unsigned f, input int unsigned ffi,
                        input bit fs, input bit te);
    exp_t e;
    e.pass_n = p; e.fail_n = f; e.ffi = ffi; e.fseen = fs; e.terr = te;
    qa.push_back(e);
  endtask

  // Returns at the negedge of the ISSUE cycle (cycle 1 of the run).
  task automatic start_a();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int n0, output int n);
    n = n0;
    while (!a_done && n < 400) begin @(negedge clk); n++; end
    if (!a_done) chk_fail("a_done_wait");
    @(negedge clk);
  endtask

  initial begin
    int n, hi;
    exp_t e;
    rst = 1'b1; stub_mute = 1'b0;
    a_wr_en = 0; a_wr_addr = '0; a_wr_pt = '0; a_wr_key = '0; a_wr_ct = '0; a_start = 0; a_abort = 0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_pt = '0; b_wr_key = '0; b_wr_ct = '0; b_start = 0; b_abort = 0;
    repeat (3) @(negedge clk);
    chk("rst_core_en", 128'(a_en), 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_done", 128'(a_done), 128'(0));
    chk("rst_counts", {a_pass, a_fail, a_ffi, a_fseen, a_terr}, 128'(0));
    chk("rst_core_data_in", a_din, 128'(0));
    chk("rst_core_key_in", a_kin, 128'(0));
    rst = 1'b0;

    // Run 1: both vectors pass; per vector 1 + 5 + 1 + 2 = 9 cycles, DONE in cycle 19.
    wr_a(1'b0, PT0, KEY0, CT0);
    wr_a(1'b1, PT1, KEY1, CT1);
    push_a(2, 0, 0, 1'b0, 1'b0);
    start_a();
    chk("run1_busy", 128'(a_busy), 128'(1));
    wait_done_a(1, n);
    chk("run1_done_cycle", 128'(n), 128'(19));
    chk("run1_idle_after_done", 128'({a_busy, a_done}), 128'(0));

    // Run 2: corrupted v1 ct written in the same cycle as start; a stray start mid-run.
    @(negedge clk);
    push_a(1, 1, 1, 1'b1, 1'b0);
    a_wr_en = 1'b1; a_wr_addr = 1'b1; a_wr_pt = PT1; a_wr_key = KEY1; a_wr_ct = CT1 ^ 128'h1;
    a_start = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0; a_start = 1'b0;
    repeat (3) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a(5, n);
    chk("run2_done_cycle", 128'(n), 128'(19));

    // Run 3: core never answers; each vector holds core_en for TIMEOUT cycles.
    wr_a(1'b1, PT1, KEY1, CT1);
    stub_mute = 1'b1;
    push_a(0, 2, 0, 1'b1, 1'b1);
    start_a();
    n = 0;
    while (!a_en && n < 20) begin @(negedge clk); n++; end
    hi = 0;
    while (a_en && hi < 40) begin @(negedge clk); hi++; end
    chk("timeout_core_en_cycles", 128'(hi), 128'(8));
    wait_done_a(1, n);
    stub_mute = 1'b0;

    // Run 4: abort while waiting on v1, then immediate restart.
    start_a();
    n = 0;
    while (!(a_pass == 2'd1 && a_en) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk_fail("abort_wait_v1");
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    chk("abort_core_en", 128'(a_en), 128'(0));
    chk("abort_busy", 128'(a_busy), 128'(0));
    chk("abort_pass_hold", 128'(a_pass), 128'(1));
    push_a(2, 0, 0, 1'b0, 1'b0);
    start_a();
    chk("restart_cleared", 128'({a_pass, a_fail, a_terr}), 128'(0));
    wr_a(1'b1, PT1, KEY1, 128'hdead);
    wait_done_a(3, n);

    // Run 5: reset during GAP, then rerun from persisted memory.
    start_a();
    n = 0;
    while (a_pass != 2'd1 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("gap_rst_busy_en_done", 128'({a_busy, a_en, a_done}), 128'(0));
    chk("gap_rst_counts", {a_pass, a_fail, a_ffi, a_fseen, a_terr}, 128'(0));
    chk("gap_rst_core_ops", a_din | a_kin, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    push_a(2, 0, 0, 1'b0, 1'b0);
    start_a();
    wait_done_a(1, n);

    // Shared-key instance: v1 key stored as zero must be replaced by v0's key.
    wr_b(1'b0, PT0, KEY0, CT0);
    wr_b(1'b1, PT1, '0, PT1 ^ KEY0);
    e.pass_n = 2; e.fail_n = 0; e.ffi = 0; e.fseen = 1'b0; e.terr = 1'b0;
    qb.push_back(e);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    n = 0;
    while (!(b_en && b_din == PT1) && n < 100) begin @(negedge clk); n++; end
    chk("shared_key_v1", b_kin, KEY0);
    n = 0;
    while (!b_done && n < 100) begin @(negedge clk); n++; end
    if (!b_done) chk_fail("b_done_wait");
    repeat (2) @(negedge clk);

    chk("a_scoreboard_drained", 128'(qa.size()), 128'(0));
    chk("b_scoreboard_drained", 128'(qb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
